// File: rtl/vr16_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : vr16_pkg
//  Description : Shared types and helpers for the VR16 decode stage.
//                - Default instruction field widths.
//                - op_class_e, the decoded instruction class code.
//                - opcode_to_class(), the opcode-to-class table.
//  Revision    : 1.0  initial release
// ============================================================================
package vr16_pkg;

    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_OPCODE_W = 4;
    localparam int DEF_REG_W    = 2;
    localparam int DEF_IMM_W    = 4;

    localparam int OP_CLASS_W   = 3;

    typedef enum logic [OP_CLASS_W-1:0] {
        OPCL_NOP     = 3'd0,
        OPCL_ALU_REG = 3'd1,
        OPCL_ALU_IMM = 3'd2,
        OPCL_LOAD    = 3'd3,
        OPCL_STORE   = 3'd4,
        OPCL_BRANCH  = 3'd5,
        OPCL_JUMP    = 3'd6,
        OPCL_ILLEGAL = 3'd7
    } op_class_e;

    // The table is defined for the 16 opcodes of the default 4-bit field.
    // The opcode is passed zero-extended, so any wider opcode value falls
    // into the ILLEGAL class.
    function automatic op_class_e opcode_to_class(input logic [31:0] opc);
        op_class_e cls;
        case (opc)
            32'd0:                             cls = OPCL_NOP;
            32'd1, 32'd2, 32'd3, 32'd4,
            32'd5, 32'd6, 32'd7:               cls = OPCL_ALU_REG;
            32'd8, 32'd9:                      cls = OPCL_ALU_IMM;
            32'd10:                            cls = OPCL_LOAD;
            32'd11:                            cls = OPCL_STORE;
            32'd12:                            cls = OPCL_BRANCH;
            32'd13:                            cls = OPCL_JUMP;
            default:                           cls = OPCL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage : vr16_pkg
`default_nettype wire

// File: rtl/decode_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : decode_skid_buffer
//  Description : Two-entry FIFO-ordered skid buffer with valid/ready on both
//                sides. All handshake outputs come from registered state.
//  Ports       : clk, reset (sync, active-high), flush (drops all entries)
//                in_data/in_valid/in_ready   - upstream handshake
//                out_data/out_valid/out_ready - downstream handshake (head)
//                deliver - high in a cycle whose rising edge completes a
//                          delivery (out_valid && out_ready, not flushed)
//  Parameters  : WIDTH - entry width in bits
//  Revision    : 1.0  initial release
// ============================================================================
module decode_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             deliver
);

    logic [1:0]       r_count;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    logic             w_push;
    logic             w_pop;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_head;

    // A flush on the same edge cancels both the accept and the delivery.
    assign w_push  = in_valid && in_ready && !flush;
    assign w_pop   = out_valid && out_ready && !flush;
    assign deliver = w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= in_data;
                    end else begin
                        r_tail <= in_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    // Harmless when only one entry is held: the head
                    // is invalid afterwards.
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Push needs count < 2 and pop needs count > 0, so the
                    // buffer holds exactly one entry here. The new word
                    // replaces the departing head and the count is unchanged.
                    r_head <= in_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : decode_skid_buffer
`default_nettype wire

// File: rtl/instruction_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode_stage
//  Description : Splits a raw instruction word into
//                opcode | reg_a | reg_b | reg_c | reg_d | imm_value
//                (MSB to LSB) and classifies the opcode. Up to two decoded
//                entries are buffered in FIFO order. Also counts deliveries.
//  Ports       : clk, reset (sync, active-high), flush
//                instruction/in_valid/in_ready - upstream handshake
//                out_valid/out_ready           - downstream handshake
//                opcode, reg_a..reg_d, imm_value, op_class - head entry
//                decoded_count - deliveries made, wraps at 16 bits
//                illegal_trap  - only with ILLEGAL_OPCODE_TRAP_EN defined
//  Options     : ILLEGAL_OPCODE_TRAP_EN - adds illegal_trap, a one-cycle
//                pulse after an ILLEGAL-class word is delivered
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_decode_stage
    import vr16_pkg::*;
#(
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int REG_W    = DEF_REG_W,
    parameter int IMM_W    = DEF_IMM_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] opcode,
    output logic [REG_W-1:0]    reg_a,
    output logic [REG_W-1:0]    reg_b,
    output logic [REG_W-1:0]    reg_c,
    output logic [REG_W-1:0]    reg_d,
    output logic [IMM_W-1:0]    imm_value,
    output logic [2:0]          op_class,
    output logic [15:0]         decoded_count
`ifdef ILLEGAL_OPCODE_TRAP_EN
    ,
    output logic                illegal_trap
`endif
);

    localparam int C_IMM_LSB  = 0;
    localparam int C_REGD_LSB = C_IMM_LSB  + IMM_W;
    localparam int C_REGC_LSB = C_REGD_LSB + REG_W;
    localparam int C_REGB_LSB = C_REGC_LSB + REG_W;
    localparam int C_REGA_LSB = C_REGB_LSB + REG_W;
    localparam int C_OPC_LSB  = C_REGA_LSB + REG_W;
    localparam int C_ENTRY_W  = OP_CLASS_W + INSTR_W;

    generate
        if (INSTR_W != OPCODE_W + 4 * REG_W + IMM_W) begin : g_bad_widths
            $fatal(1, "instruction_decode_stage: INSTR_W must equal OPCODE_W + 4*REG_W + IMM_W");
        end
    endgenerate

    op_class_e              w_in_class;
    logic [C_ENTRY_W-1:0]   w_in_entry;
    logic [C_ENTRY_W-1:0]   w_head_entry;
    logic                   w_deliver;
    logic [15:0]            r_decoded_count;

    // Classify on the way in so each buffered entry carries its class
    // beside the raw word.
    assign w_in_class = opcode_to_class(32'(instruction[C_OPC_LSB +: OPCODE_W]));
    assign w_in_entry = {w_in_class, instruction};

    decode_skid_buffer #(
        .WIDTH     (C_ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_data   (w_in_entry),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (w_head_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .deliver   (w_deliver)
    );

    // The fields are slices of the registered head entry. They hold steady
    // while stalled and read as zero after reset.
    assign opcode    = w_head_entry[C_OPC_LSB  +: OPCODE_W];
    assign reg_a     = w_head_entry[C_REGA_LSB +: REG_W];
    assign reg_b     = w_head_entry[C_REGB_LSB +: REG_W];
    assign reg_c     = w_head_entry[C_REGC_LSB +: REG_W];
    assign reg_d     = w_head_entry[C_REGD_LSB +: REG_W];
    assign imm_value = w_head_entry[C_IMM_LSB  +: IMM_W];
    assign op_class  = w_head_entry[C_ENTRY_W-1 -: OP_CLASS_W];

    // Flush leaves the count alone. w_deliver is already low on a flush edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_decoded_count <= 16'd0;
        end else if (w_deliver) begin
            r_decoded_count <= r_decoded_count + 16'd1;
        end
    end

    assign decoded_count = r_decoded_count;

`ifdef ILLEGAL_OPCODE_TRAP_EN
    logic r_illegal_trap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_trap <= 1'b0;
        end else begin
            r_illegal_trap <= w_deliver && (op_class == OPCL_ILLEGAL);
        end
    end

    assign illegal_trap = r_illegal_trap;
`endif

endmodule : instruction_decode_stage
`default_nettype wire
